// File: rtl/iob_ibus_dbus_arbiter.sv
// Two-requester IOb arbiter: CPU instruction bus (read-only) and data bus share one memory port.
// Define IOB_ARB_ROUND_ROBIN_EN for alternating priority; otherwise the data bus always wins.
module iob_ibus_dbus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cke_i,

    input  logic                ibus_avalid,
    input  logic [ADDR_W-1:0]   ibus_address,
    output logic                ibus_aready,
    output logic [DATA_W-1:0]   ibus_rdata,
    output logic                ibus_rvalid,

    input  logic                dbus_avalid,
    input  logic [ADDR_W-1:0]   dbus_address,
    input  logic [DATA_W-1:0]   dbus_wdata,
    input  logic [DATA_W/8-1:0] dbus_wstrb,
    output logic                dbus_aready,
    output logic [DATA_W-1:0]   dbus_rdata,
    output logic                dbus_rvalid,

    output logic                mem_avalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_aready,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_rvalid
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t     state;
    logic [1:0] grant;      // one-hot {dbus, ibus}; 2'b00 = no grant
    logic       is_write;
    logic       pick_dbus;
    logic       accept;
    logic       respond;

`ifdef IOB_ARB_ROUND_ROBIN_EN
    logic last_grant_dbus;

    // On contention the requester that did not complete last goes first.
    assign pick_dbus = dbus_avalid && (!ibus_avalid || !last_grant_dbus);
`else
    assign pick_dbus = dbus_avalid;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            grant       <= 2'b00;
            is_write    <= 1'b0;
            mem_avalid  <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= '0;
`ifdef IOB_ARB_ROUND_ROBIN_EN
            last_grant_dbus <= 1'b1;
`endif
        end else if (cke_i) begin
            case (state)
                IDLE: begin
                    if (ibus_avalid || dbus_avalid) begin
                        if (pick_dbus) begin
                            grant       <= 2'b10;
                            mem_address <= dbus_address;
                            mem_wdata   <= dbus_wdata;
                            mem_wstrb   <= dbus_wstrb;
                            is_write    <= |dbus_wstrb;
                        end else begin
                            grant       <= 2'b01;
                            mem_address <= ibus_address;
                            mem_wdata   <= '0;
                            mem_wstrb   <= '0;
                            is_write    <= 1'b0;
                        end
                        mem_avalid <= 1'b1;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mem_aready) begin
                        mem_avalid <= 1'b0;
                        if (is_write) begin
                            state <= IDLE;
                            grant <= 2'b00;
`ifdef IOB_ARB_ROUND_ROBIN_EN
                            last_grant_dbus <= grant[1];
`endif
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (mem_rvalid) begin
                        state <= IDLE;
                        grant <= 2'b00;
`ifdef IOB_ARB_ROUND_ROBIN_EN
                        last_grant_dbus <= grant[1];
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake returns are gated by cke_i so a frozen FSM never reports progress.
    assign accept  = cke_i && (state == ACCESS) && mem_aready;
    assign respond = cke_i && (state == RESP) && mem_rvalid;

    assign ibus_aready = accept && grant[0];
    assign dbus_aready = accept && grant[1];
    assign ibus_rvalid = respond && grant[0];
    assign dbus_rvalid = respond && grant[1];
    assign ibus_rdata  = mem_rdata;
    assign dbus_rdata  = mem_rdata;

endmodule
